// File: rtl/onehot_pulse_decoder.sv
// -----------------------------------------------------------------------------
// onehot_pulse_decoder
//
// Accepts a binary index over a valid/ready handshake and drives the matching
// one-hot output line for PULSE_CYCLES cycles. While a pulse is running the
// block back-pressures. An index at or above WIDTH is consumed, and no line is
// driven for it. Instead, err pulses for one cycle.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// ready depends only on registered state and reset_n. The producer may hold
// valid/idx for as long as it likes until the transfer occurs.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset_n   in   1      asynchronous, active-low reset
//   idx       in   IW     index to decode
//   valid     in   1      idx is presented
//   ready     out  1      block can accept this cycle
//   out       out  WIDTH  registered one-hot output, zero when idle
//   busy      out  1      registered, high while out is driven
//   err       out  1      registered one-cycle pulse after an out-of-range index
//   dbg_state out  1      FSM state, 1 = DRIVE, 0 = IDLE
// -----------------------------------------------------------------------------
module onehot_pulse_decoder #(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 1,
  localparam int IW = $clog2(WIDTH),
  localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IW-1:0]    idx,
  input  logic             valid,
  output logic             ready,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             err,
  output logic             dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  localparam logic [CW-1:0] CNT_RELOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [IW:0]   WIDTH_EXT  = (IW + 1)'(WIDTH);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  out_q, out_d;

  logic              xfer;
  logic              in_range;

  // cnt_q counts the extra cycles left after the current one. The final DRIVE
  // cycle (cnt_q == 0) accepts, so back-to-back pulses have no gap.
  assign ready = reset_n && ((state_q == IDLE) || (cnt_q == '0));
  assign xfer  = valid && ready;

  // The index is widened by one bit so that the compare also works when WIDTH
  // is a power of two. In that case every index is in range.
  assign in_range = ({1'b0, idx} < WIDTH_EXT);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An accepted index replaces whatever the case above decided. This is
    // reached only from IDLE or from the final DRIVE cycle.
    if (xfer) begin
      if (in_range) begin
        state_d = DRIVE;
        idx_d   = idx;
        cnt_d   = CNT_RELOAD;
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end

    // The output is registered. It is computed from the next state, so out
    // changes on the same edge as the state. It can only be one-hot or zero.
    out_d = '0;
    if (state_d == DRIVE) begin
      out_d = WIDTH'(1) << idx_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign out       = out_q;
  assign busy      = (state_q == DRIVE);
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for onehot_pulse_decoder. Five instances cover the parameter sets
// used by the scenarios:
//   u0: WIDTH=8, PULSE=3
//   u1: WIDTH=8, PULSE=1
//   u2: WIDTH=6, PULSE=2
//   u3: WIDTH=8, PULSE=4
//   u4: WIDTH=8, PULSE=2
// All instances share clk and reset_n.
//
// The model keeps, for each instance, the number of cycles the current pulse
// still has to run (including the present one), the line being driven, and
// the err flag. It checks every instance on every falling edge. Directed
// literal checks pin the expected waveforms.
// -----------------------------------------------------------------------------
module tb_onehot_pulse_decoder;

  localparam int N = 5;

  logic          clk;
  logic          reset_n;
  logic [N-1:0]  valid_v;
  logic [2:0]    idx_a [N];
  wire  [N-1:0]  ready_v;
  wire  [N-1:0]  busy_v;
  wire  [N-1:0]  err_v;
  wire  [N-1:0]  dbg_v;
  wire  [7:0]    out0, out1, out3, out4;
  wire  [5:0]    out2;
  logic [7:0]    out_a [N];

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  // Behavioural model state
  int m_rem [N] = '{default: 0};
  int m_cur [N] = '{default: 0};
  bit m_err [N] = '{default: 1'b0};

  onehot_pulse_decoder #(.WIDTH(8), .PULSE_CYCLES(3)) u0 (
    .clk(clk), .reset_n(reset_n), .idx(idx_a[0]), .valid(valid_v[0]),
    .ready(ready_v[0]), .out(out0), .busy(busy_v[0]), .err(err_v[0]),
    .dbg_state(dbg_v[0]));
  onehot_pulse_decoder #(.WIDTH(8), .PULSE_CYCLES(1)) u1 (
    .clk(clk), .reset_n(reset_n), .idx(idx_a[1]), .valid(valid_v[1]),
    .ready(ready_v[1]), .out(out1), .busy(busy_v[1]), .err(err_v[1]),
    .dbg_state(dbg_v[1]));
  onehot_pulse_decoder #(.WIDTH(6), .PULSE_CYCLES(2)) u2 (
    .clk(clk), .reset_n(reset_n), .idx(idx_a[2]), .valid(valid_v[2]),
    .ready(ready_v[2]), .out(out2), .busy(busy_v[2]), .err(err_v[2]),
    .dbg_state(dbg_v[2]));
  onehot_pulse_decoder #(.WIDTH(8), .PULSE_CYCLES(4)) u3 (
    .clk(clk), .reset_n(reset_n), .idx(idx_a[3]), .valid(valid_v[3]),
    .ready(ready_v[3]), .out(out3), .busy(busy_v[3]), .err(err_v[3]),
    .dbg_state(dbg_v[3]));
  onehot_pulse_decoder #(.WIDTH(8), .PULSE_CYCLES(2)) u4 (
    .clk(clk), .reset_n(reset_n), .idx(idx_a[4]), .valid(valid_v[4]),
    .ready(ready_v[4]), .out(out4), .busy(busy_v[4]), .err(err_v[4]),
    .dbg_state(dbg_v[4]));

  always_comb begin
    out_a[0] = out0;
    out_a[1] = out1;
    out_a[2] = {2'b00, out2};
    out_a[3] = out3;
    out_a[4] = out4;
  end

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic int w_of(input int i);
    return (i == 2) ? 6 : 8;
  endfunction

  function automatic int p_of(input int i);
    case (i)
      0:       return 3;
      1:       return 1;
      2:       return 2;
      3:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] exp_out(input int i);
    return (m_rem[i] > 0) ? (8'd1 << m_cur[i]) : 8'd0;
  endfunction

  function automatic logic exp_ready(input int i);
    return reset_n && (m_rem[i] <= 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [2:0] ix);
    valid_v[i] = v;
    idx_a[i]   = ix;
  endtask

  // ---------------- behavioural model ----------------
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_rem[i] <= 0;
        m_cur[i] <= 0;
        m_err[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (valid_v[i] && (m_rem[i] <= 1)) begin
          if (int'(idx_a[i]) < w_of(i)) begin
            m_rem[i] <= p_of(i);
            m_cur[i] <= int'(idx_a[i]);
            m_err[i] <= 1'b0;
          end else begin
            m_rem[i] <= 0;
            m_err[i] <= 1'b1;
          end
        end else begin
          if (m_rem[i] > 0) m_rem[i] <= m_rem[i] - 1;
          m_err[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("u%0d_out", i),   32'(out_a[i]),  32'(exp_out(i)));
        check($sformatf("u%0d_busy", i),  32'(busy_v[i]), 32'(m_rem[i] > 0));
        check($sformatf("u%0d_err", i),   32'(err_v[i]),  32'(m_err[i]));
        check($sformatf("u%0d_ready", i), 32'(ready_v[i]), 32'(exp_ready(i)));
        check($sformatf("u%0d_state", i), 32'(dbg_v[i]),  32'(m_rem[i] > 0));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n = 1'b0;
    valid_v = '0;
    for (int i = 0; i < N; i++) idx_a[i] = 3'd0;

    // Reset state
    step();
    chk_en = 1'b1;
    step();
    check("rst_out",   32'(out0),       32'h0);
    check("rst_busy",  32'(busy_v[0]),  32'h0);
    check("rst_err",   32'(err_v[0]),   32'h0);
    check("rst_ready", 32'(ready_v[0]), 32'h0);

    reset_n = 1'b1;
    #1;
    check("rel_ready0", 32'(ready_v[0]), 32'h1);
    check("rel_ready1", 32'(ready_v[1]), 32'h1);

    // Basic pulse: u0, idx=5, 3 cycles
    drive(0, 1'b1, 3'd5);
    step();
    drive(0, 1'b0, 3'd0);
    check("basic_c1_out",   32'(out0), 32'h20);
    check("basic_c1_ready", 32'(ready_v[0]), 32'h0);
    step();
    check("basic_c2_out",   32'(out0), 32'h20);
    check("basic_c2_ready", 32'(ready_v[0]), 32'h0);
    step();
    check("basic_c3_out",   32'(out0), 32'h20);
    check("basic_c3_ready", 32'(ready_v[0]), 32'h1);
    step();
    check("basic_end_out",  32'(out0), 32'h0);
    check("basic_end_busy", 32'(busy_v[0]), 32'h0);

    // Back-to-back: u0, idx=2 then idx=7 held until accepted
    drive(0, 1'b1, 3'd2);
    step();
    drive(0, 1'b1, 3'd7);
    check("b2b_a1", 32'(out0), 32'h04);
    step();
    check("b2b_a2", 32'(out0), 32'h04);
    step();
    check("b2b_a3", 32'(out0), 32'h04);
    step();
    drive(0, 1'b0, 3'd0);
    check("b2b_b1", 32'(out0), 32'h80);
    step();
    check("b2b_b2", 32'(out0), 32'h80);
    step();
    check("b2b_b3", 32'(out0), 32'h80);
    step();
    check("b2b_end", 32'(out0), 32'h0);

    // Repeat index: u1 (PULSE=1), idx=3 for 4 cycles
    drive(1, 1'b1, 3'd3);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rep_out%0d", k),   32'(out1), 32'h08);
      check($sformatf("rep_ready%0d", k), 32'(ready_v[1]), 32'h1);
    end
    drive(1, 1'b0, 3'd0);
    step();
    check("rep_end", 32'(out1), 32'h0);

    // Out-of-range: u2 (WIDTH=6, PULSE=2)
    drive(2, 1'b1, 3'd6);
    step();
    check("oor6_err",  32'(err_v[2]),  32'h1);
    check("oor6_out",  32'(out2),      32'h0);
    check("oor6_busy", 32'(busy_v[2]), 32'h0);
    drive(2, 1'b1, 3'd7);
    step();
    check("oor7_err",  32'(err_v[2]),  32'h1);
    check("oor7_out",  32'(out2),      32'h0);
    drive(2, 1'b1, 3'd0);
    step();
    drive(2, 1'b0, 3'd0);
    check("oor_ok_out1", 32'(out2),     32'h01);
    check("oor_ok_err",  32'(err_v[2]), 32'h0);
    step();
    check("oor_ok_out2", 32'(out2), 32'h01);
    step();
    check("oor_ok_end",  32'(out2), 32'h0);

    // Reset mid-pulse: u3 (PULSE=4)
    drive(3, 1'b1, 3'd1);
    step();
    drive(3, 1'b0, 3'd0);
    check("mid_c1", 32'(out3), 32'h02);
    step();
    step();
    check("mid_c3", 32'(out3), 32'h02);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out",   32'(out3),       32'h0);
    check("mid_rst_busy",  32'(busy_v[3]),  32'h0);
    check("mid_rst_ready", 32'(ready_v[3]), 32'h0);
    step();
    reset_n = 1'b1;
    #1;
    check("mid_rel_ready", 32'(ready_v[3]), 32'h1);
    step();
    check("mid_rel_out", 32'(out3), 32'h0);
    drive(3, 1'b1, 3'd4);
    step();
    drive(3, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mid_new%0d", k), 32'(out3), 32'h10);
      step();
    end
    check("mid_new_end", 32'(out3), 32'h0);

    // Valid gaps: u4 (PULSE=2), idx=0, two idle cycles, idx=0
    drive(4, 1'b1, 3'd0);
    step();
    drive(4, 1'b0, 3'd0);
    check("gap_a1", 32'(out4), 32'h01);
    step();
    check("gap_a2", 32'(out4), 32'h01);
    step();
    check("gap_z1", 32'(out4), 32'h00);
    step();
    check("gap_z2", 32'(out4), 32'h00);
    drive(4, 1'b1, 3'd0);
    step();
    drive(4, 1'b0, 3'd0);
    check("gap_b1", 32'(out4), 32'h01);
    check("gap_err", 32'(err_v[4]), 32'h0);
    step();
    check("gap_b2", 32'(out4), 32'h01);
    step();
    check("gap_end", 32'(out4), 32'h0);

    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
